// File: rtl/uart_ram_loader_if.sv
// Bundle of the loader's UART input, instruction-RAM write port and CPU/status outputs.
// The loader uses the master side; the top level or testbench drives uart_rx.
interface uart_ram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  uart_rx;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  cpu_halt;
    logic                  busy;
    logic                  load_done;
    logic                  load_error;

    modport master (
        input  uart_rx,
        output ram_we, ram_addr, ram_wdata, cpu_halt, busy, load_done, load_error
    );

    modport slave (
        output uart_rx,
        input  ram_we, ram_addr, ram_wdata, cpu_halt, busy, load_done, load_error
    );
endinterface

// File: rtl/uart_ram_loader.sv
// Receives a framed program image over UART 8N1 and writes it into the instruction RAM,
// holding the CPU halted while a frame is in progress.
module uart_ram_loader #(
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CLKS = 2_500_000
) (
    input logic               clk_25mhz,
    input logic               reset,
    uart_ram_loader_if.master bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned WL_W         = ADDR_WIDTH + 1;
    localparam logic [7:0]  HEADER       = 8'hA5;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {StIdle, StCount, StData, StWrite, StCheck, StErr} state_e;

    // UART receiver
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid;
    logic             frame_err;

    // Frame loader
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WL_W-1:0]       words_left_q, words_left_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            xor_q, xor_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  halt_q, halt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  in_frame;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q  <= bus.uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                clk_cnt_d = '0;
                // Edge rather than level, so a line stuck low after a bad stop bit
                // does not retrigger continuously.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d  = '0;
                    byte_valid = rx_sync_q;
                    frame_err  = !rx_sync_q;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            xor_q        <= '0;
            to_cnt_q     <= '0;
            halt_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            xor_q        <= xor_d;
            to_cnt_q     <= to_cnt_d;
            halt_q       <= halt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_frame = (state_q == StCount) || (state_q == StData) ||
                      (state_q == StWrite) || (state_q == StCheck);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        xor_d        = xor_q;
        to_cnt_d     = '0;
        halt_d       = halt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;

        if (in_frame && !byte_valid) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (byte_valid && shift_q == HEADER) begin
                    halt_d     = 1'b1;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    addr_d     = '0;
                    xor_d      = '0;
                    byte_idx_d = '0;
                    state_d    = StCount;
                end
            end
            StCount: begin
                if (byte_valid) begin
                    // A count of zero means a full RAM image.
                    words_left_d = (shift_q == 8'd0) ? (WL_W'(1) << ADDR_WIDTH)
                                                     : WL_W'(shift_q);
                    state_d = StData;
                end
            end
            StData: begin
                if (byte_valid) begin
                    wdata_d[8*byte_idx_q +: 8] = shift_q;
                    xor_d      = xor_q ^ shift_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d       = addr_q + 1'b1;
                words_left_d = words_left_q - 1'b1;
                state_d      = (words_left_q == WL_W'(1)) ? StCheck : StData;
            end
            StCheck: begin
                if (byte_valid) begin
                    if (shift_q == xor_q) begin
                        done_d  = 1'b1;
                        halt_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort conditions override any progress made above.
        if (in_frame && (frame_err || to_cnt_q == TO_W'(TIMEOUT_CLKS - 1))) begin
            state_d = StErr;
        end
    end

    assign bus.ram_we     = (state_q == StWrite);
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.cpu_halt   = halt_q;
    assign bus.busy       = busy_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: sends UART frames and checks RAM writes and status.
// Runs at 8 clocks per bit with a short timeout to keep simulation fast.
module tb_uart_ram_loader;

    localparam int unsigned CPB     = 8;
    localparam int unsigned TIMEOUT = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;

    uart_ram_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
    assign bus.uart_rx = rx;

    uart_ram_loader #(
        .CLK_HZ      (1_000_000),
        .BAUD        (125_000),
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .TIMEOUT_CLKS(TIMEOUT)
    ) dut (
        .clk_25mhz(clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt     = 0;
    int          done_cnt   = 0;
    int          excl_viol  = 0;
    int          base_wr;
    int          base_done;
    logic [7:0]  frame [$];

    always @(negedge clk) begin
        if (bus.ram_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = bus.ram_addr;
                wr_data[wr_cnt] = bus.ram_wdata;
            end
            wr_cnt++;
        end
        if (bus.load_done) done_cnt++;
        if (bus.ram_we && bus.load_done) excl_viol++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    task automatic mark();
        base_wr   = wr_cnt;
        base_done = done_cnt;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_we",    64'(bus.ram_we), 0);
        check("rst_addr",  64'(bus.ram_addr), 0);
        check("rst_halt",  64'(bus.cpu_halt), 0);
        check("rst_busy",  64'(bus.busy), 0);
        check("rst_done",  64'(bus.load_done), 0);
        check("rst_err",   64'(bus.load_error), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 1: single word
        mark();
        frame = '{8'hA5, 8'h01};
        send_frame();
        check("t1_halt_mid", 64'(bus.cpu_halt), 1);
        check("t1_busy_mid", 64'(bus.busy), 1);
        frame = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_frame();
        repeat (10) @(negedge clk);
        check("t1_nwr",  64'(wr_cnt - base_wr), 1);
        check("t1_addr", 64'(wr_addr[base_wr]), 0);
        check("t1_data", 64'(wr_data[base_wr]), 64'h12345678);
        check("t1_done", 64'(done_cnt - base_done), 1);
        check("t1_halt", 64'(bus.cpu_halt), 0);
        check("t1_busy", 64'(bus.busy), 0);

        // 2: three words
        mark();
        frame = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
        send_frame();
        repeat (10) @(negedge clk);
        check("t2_nwr",   64'(wr_cnt - base_wr), 3);
        check("t2_addr0", 64'(wr_addr[base_wr]), 0);
        check("t2_addr1", 64'(wr_addr[base_wr+1]), 1);
        check("t2_addr2", 64'(wr_addr[base_wr+2]), 2);
        check("t2_data0", 64'(wr_data[base_wr]), 64'h04030201);
        check("t2_data2", 64'(wr_data[base_wr+2]), 64'h0C0B0A09);
        check("t2_done",  64'(done_cnt - base_done), 1);
        check("t2_busy",  64'(bus.busy), 0);
        check("t2_err",   64'(bus.load_error), 0);

        // 3: leading junk ignored
        mark();
        frame = '{8'h00, 8'hFF, 8'h11, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_frame();
        repeat (10) @(negedge clk);
        check("t3_nwr",  64'(wr_cnt - base_wr), 1);
        check("t3_addr", 64'(wr_addr[base_wr]), 0);
        check("t3_data", 64'(wr_data[base_wr]), 64'h04030201);
        check("t3_done", 64'(done_cnt - base_done), 1);

        // 4: bad checksum, then recovery
        mark();
        frame = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_frame();
        repeat (10) @(negedge clk);
        check("t4_err",  64'(bus.load_error), 1);
        check("t4_halt", 64'(bus.cpu_halt), 1);
        check("t4_busy", 64'(bus.busy), 0);
        check("t4_done", 64'(done_cnt - base_done), 0);
        frame = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_frame();
        repeat (10) @(negedge clk);
        check("t4_err_clr",  64'(bus.load_error), 0);
        check("t4_halt_clr", 64'(bus.cpu_halt), 0);
        check("t4_done2",    64'(done_cnt - base_done), 1);

        // 5: timeout after one word of two
        mark();
        frame = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame();
        check("t5_busy_mid", 64'(bus.busy), 1);
        repeat (TIMEOUT + 100) @(negedge clk);
        check("t5_nwr",  64'(wr_cnt - base_wr), 1);
        check("t5_addr", 64'(wr_addr[base_wr]), 0);
        check("t5_err",  64'(bus.load_error), 1);
        check("t5_busy", 64'(bus.busy), 0);
        check("t5_halt", 64'(bus.cpu_halt), 1);

        // Glitch in idle must not start a byte that would swallow the following header.
        mark();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        frame = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_frame();
        repeat (10) @(negedge clk);
        check("glitch_done", 64'(done_cnt - base_done), 1);
        check("glitch_data", 64'(wr_data[base_wr]), 64'h04030201);
        check("glitch_err",  64'(bus.load_error), 0);

        // 6: reset during the third data byte
        frame = '{8'hA5, 8'h01, 8'hAA, 8'hBB};
        send_frame();
        rx = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rx = 1'b1;
        check("t6_we",    64'(bus.ram_we), 0);
        check("t6_addr",  64'(bus.ram_addr), 0);
        check("t6_wdata", 64'(bus.ram_wdata), 0);
        check("t6_halt",  64'(bus.cpu_halt), 0);
        check("t6_busy",  64'(bus.busy), 0);
        check("t6_err",   64'(bus.load_error), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        mark();
        frame = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_frame();
        repeat (10) @(negedge clk);
        check("t6_nwr",  64'(wr_cnt - base_wr), 1);
        check("t6_addr", 64'(wr_addr[base_wr]), 0);
        check("t6_data", 64'(wr_data[base_wr]), 64'hEFBEADDE);
        check("t6_done", 64'(done_cnt - base_done), 1);

        check("we_done_excl", 64'(excl_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
